// File: rtl/gen_scheduler.sv
// Game of Life generation scheduler: turns run/step/speed into iteration start pulses,
// arbitrates field memory with the edit path. Optional watchdog: define SCHED_WDOG_EN.
module gen_scheduler #(
    parameter int TICK_BASE = 1_000_000,
    parameter int GEN_BITS  = 16,
    parameter int WDOG_MAX  = 65_535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_run,
    input  logic                i_step,
    input  logic [2:0]          i_speed,
    input  logic                i_window,
    input  logic                i_nfi_done,
    input  logic                i_edit_req,
    output logic                o_nfi_start,
    output logic                o_edit_gnt,
    output logic                o_busy,
    output logic [GEN_BITS-1:0] o_gen
`ifdef SCHED_WDOG_EN
    ,
    output logic                o_timeout
`endif
);

    localparam int CNT_W = $clog2(TICK_BASE * 8 + 1);

    if (TICK_BASE < 2) begin : g_bad_tick_base
        $error("gen_scheduler: TICK_BASE must be at least 2");
    end
    if (WDOG_MAX < 1) begin : g_bad_wdog_max
        $error("gen_scheduler: WDOG_MAX must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, START, BUSY, EDIT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tick_cnt;
    logic [CNT_W-1:0]   period_q;
    logic               pending;
    logic               tick_wrap;
    logic               take_pending;
    logic               wdog_fire;

    function automatic logic [CNT_W-1:0] period_of(input logic [2:0] spd);
        return CNT_W'(TICK_BASE * (8 - int'(spd)));
    endfunction

    assign tick_wrap    = i_run && (tick_cnt == period_q - CNT_W'(1));
    assign take_pending = (state_q == IDLE) && !i_edit_req && pending && i_window;

    // Period is latched only at wrap so a speed change never truncates the current period.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            period_q <= period_of(i_speed);
            pending  <= 1'b0;
        end else begin
            if (tick_wrap) begin
                tick_cnt <= '0;
                period_q <= period_of(i_speed);
            end else if (i_run) begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end
            pending <= tick_wrap || (i_step && !i_run) || (pending && !take_pending);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_edit_req)               state_d = EDIT;
                else if (pending && i_window) state_d = START;
            end
            START: state_d = BUSY;
            BUSY: begin
                if (i_nfi_done || wdog_fire) state_d = IDLE;
            end
            EDIT: begin
                if (!i_edit_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)                                  o_gen <= '0;
        else if (state_q == BUSY && i_nfi_done)   o_gen <= o_gen + GEN_BITS'(1);
    end

`ifdef SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_MAX + 1);

    logic [WDOG_W-1:0] wdog_cnt;

    // Counter value equals the number of BUSY cycles already spent in this iteration.
    assign wdog_fire = (state_q == BUSY) && !i_nfi_done && (wdog_cnt == WDOG_W'(WDOG_MAX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_cnt  <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (state_q == BUSY) wdog_cnt <= wdog_cnt + WDOG_W'(1);
            else                 wdog_cnt <= '0;
            if (wdog_fire)       o_timeout <= 1'b1;
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    assign o_nfi_start = (state_q == START);
    assign o_busy      = (state_q == BUSY);
    assign o_edit_gnt  = (state_q == EDIT);

endmodule
